dpram_arbiter: RTL and testbench
================================

# dpram_arbiter

Two-port round-robin arbiter that shares one `dual_port_ram` (8-bit data, 64 words) among `NREQ` requesters. Each cycle it picks up to two requests and drives them onto RAM port A and port B, keeping two requests to the same address apart when either one writes. It also returns read data to the correct requester one cycle later. It sits between the requester logic and the RAM, and it owns every RAM port pin.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `AW`, 6: address width.
- `DW`, 8: data width.

Ports:
- `clk` input 1: single clock; everything samples on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input NREQ: request per requester; hold until granted.
- `we` input NREQ: 1 = write, 0 = read, per requester.
- `addr` input NREQ*AW: packed addresses; requester i uses bits [i*AW +: AW].
- `wdata` input NREQ*DW: packed write data.
- `gnt` output NREQ: combinational grant; a request is accepted when `req[i] & gnt[i]`.
- `rvalid` output NREQ: read data valid for requester i.
- `rdata` output NREQ*DW: read data lane per requester; only meaningful while `rvalid[i]` is high.
- `ram_addr_a`, `ram_addr_b` output AW: RAM addresses.
- `ram_data_a`, `ram_data_b` output DW: RAM write data.
- `ram_we_a`, `ram_we_b` output 1: RAM write enables.
- `ram_q_a`, `ram_q_b` input DW: RAM read data, valid the cycle after the address is sampled.

## Operation
- State held: round-robin pointer `ptr` (index 0..NREQ-1), plus one return tag per port (`valid`, `idx`).
- Port A selection: the first `i` with `req[i]=1`, searching in order `ptr`, `ptr+1`, … modulo NREQ.
- Port B selection: continue the same search after the port A winner.
  - Skip a candidate if its address equals the port A address and either request is a write.
  - The first candidate that is not skipped wins port B.
- At most two grants per cycle; `gnt` is one-hot per port.
- Ungranted ports drive `we=0`, `addr=0`, `data=0`.
- Pointer update: if port A is granted, `ptr <= (A index + 1) mod NREQ`; otherwise `ptr` holds.
- Return path:
  - A granted read sets that port's tag to `{1, idx}`; a write or no grant clears it.
  - Next cycle, `rvalid[idx]=1` and `rdata` lane `idx` = `ram_q` of that port.
  - Tags are registered; `rvalid` is combinational from the tags.
- No two requesters can receive `rvalid` on the same lane in one cycle. Each requester wins at most one port per cycle.
- Fairness: a requester that keeps `req` asserted is granted within NREQ-1 cycles.
- A requester may deassert `req` before it is granted; no state is kept for it.

## Timing
- Grant latency: 0 cycles, combinational from `req`/`addr`/`we`.
- Write: committed at the rising edge that ends the grant cycle.
- Read: `rvalid`/`rdata` appear in the cycle after the grant, for exactly one cycle.
- Back-to-back reads by the same requester produce consecutive `rvalid` pulses.
- Reset values (asynchronous assertion): `ptr=0`, both tags invalid, `rvalid=0`, `gnt=0`, all RAM outputs 0.
- Reset is released synchronously to `clk`.
- Reset in the middle of a read discards the pending `rvalid`.
- Write followed by a read to the same address in the next cycle returns the new data.

## Configuration
- `DPRAM_ARB_STATS_EN` defined adds two outputs:
  - `stat_grants` (16 bit): grants issued, +0/+1/+2 per cycle.
  - `stat_conflicts` (16 bit): cycles in which at least one candidate was skipped for an address conflict.
  - Both counters saturate at 16'hFFFF and clear on `rst`.
- Without the macro, neither port nor counter exists, and behaviour is otherwise identical.

## Structure
- Package `dpram_arb_pkg` holds:
  - defaults `NREQ_DEF=4`, `AW_DEF=6`, `DW_DEF=8`;
  - typedef `port_tag_t {logic valid; logic [2:0] idx;}`;
  - constant `STAT_W=16`.
- Sub-module `rr_pick`: input a request vector, start index, and mask; output a found flag and a one-hot/index. Instantiated twice, once for port A and once for port B with the conflict mask.

## Test plan
- Reset, then requester 0 writes 8'h55 to addr 6'h01 and requester 1 writes 8'h66 to addr 6'h02 together → `gnt=4'b0011` in one cycle; `ram_we_a=ram_we_b=1`; `ptr` becomes 1.
- Next cycle, requester 2 reads 6'h02 and requester 3 reads 6'h01 → both granted; one cycle later `rvalid=4'b1100`, with lane 2 = 8'h66 and lane 3 = 8'h55.
- Requesters 0 and 1 both write addr 6'h10 → only one is granted per cycle; both are granted within 2 cycles; `stat_conflicts` increments (with stats enabled).
- All 4 requesters hold reads of distinct addresses for 8 cycles → each requester granted 4 times; grant pairs rotate (0,1), (1,2), (2,3), (3,0), ….
- Grant a read, then assert `rst` before the next edge → `rvalid` stays 0; after release, `ptr=0` and the first grant goes to the lowest requesting index.
- A single requester (index 3) alone issues reads to 6'h00..6'h3F on consecutive cycles → 64 consecutive `rvalid[3]` pulses with data matching earlier writes; port B stays idle.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// Shared types and defaults for the dual-port RAM arbiter.
package dpram_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 6;
  localparam int DW_DEF   = 8;
  localparam int STAT_W   = 16;
  localparam int IDX_W    = 3;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } port_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one search: returns the first masked request at or after start.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  mask,
  output logic          found,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  always_comb begin : search
    int pos;
    found  = 1'b0;
    onehot = '0;
    idx    = '0;
    pos    = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos] && mask[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing a dual-port RAM among NREQ requesters.
// Define DPRAM_ARB_STATS_EN to add saturating grant/conflict counters.
import dpram_arb_pkg::*;

module dpram_arbiter #(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [NREQ*DW-1:0] rdata,
`ifdef DPRAM_ARB_STATS_EN
  output logic [STAT_W-1:0]  stat_grants,
  output logic [STAT_W-1:0]  stat_conflicts,
`endif
  output logic [AW-1:0]      ram_addr_a,
  output logic [AW-1:0]      ram_addr_b,
  output logic [DW-1:0]      ram_data_a,
  output logic [DW-1:0]      ram_data_b,
  output logic               ram_we_a,
  output logic               ram_we_b,
  input  logic [DW-1:0]      ram_q_a,
  input  logic [DW-1:0]      ram_q_b
);

  logic [IDX_W-1:0] ptr, idx_a, idx_b, start_b;
  logic             found_a, found_b;
  logic [NREQ-1:0]  req_q, oh_a, oh_b, conflict, mask_b;
  logic [AW-1:0]    addr_a_sel;
  logic             we_a_sel;
  port_tag_t        tag_a, tag_b;

  // Requests are ignored while reset is held so no RAM pin toggles.
  assign req_q = rst ? '0 : req;

  rr_pick #(.N(NREQ), .IW(IDX_W)) u_pick_a (
    .req(req_q), .start(ptr), .mask({NREQ{1'b1}}),
    .found(found_a), .onehot(oh_a), .idx(idx_a)
  );

  assign addr_a_sel = addr[idx_a*AW +: AW];
  assign we_a_sel   = we[idx_a];

  always_comb begin
    conflict = '0;
    for (int i = 0; i < NREQ; i++) begin
      conflict[i] = (addr[i*AW +: AW] == addr_a_sel) && (we[i] || we_a_sel);
    end
  end

  assign mask_b  = ~oh_a & ~conflict;
  assign start_b = (idx_a == IDX_W'(NREQ-1)) ? '0 : idx_a + 1'b1;

  rr_pick #(.N(NREQ), .IW(IDX_W)) u_pick_b (
    .req(req_q), .start(start_b), .mask(mask_b),
    .found(found_b), .onehot(oh_b), .idx(idx_b)
  );

  assign gnt        = oh_a | oh_b;
  assign ram_we_a   = found_a & we_a_sel;
  assign ram_addr_a = found_a ? addr_a_sel : '0;
  assign ram_data_a = found_a ? wdata[idx_a*DW +: DW] : '0;
  assign ram_we_b   = found_b & we[idx_b];
  assign ram_addr_b = found_b ? addr[idx_b*AW +: AW] : '0;
  assign ram_data_b = found_b ? wdata[idx_b*DW +: DW] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      tag_a <= '0;
      tag_b <= '0;
    end else begin
      if (found_a) ptr <= start_b;
      if (found_a && !we_a_sel) begin
        tag_a.valid <= 1'b1;
        tag_a.idx   <= idx_a;
      end else begin
        tag_a <= '0;
      end
      if (found_b && !we[idx_b]) begin
        tag_b.valid <= 1'b1;
        tag_b.idx   <= idx_b;
      end else begin
        tag_b <= '0;
      end
    end
  end

  // Each requester holds at most one port, so the two tags never share a lane.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (tag_a.valid && tag_a.idx == IDX_W'(i)) begin
        rvalid[i]          = 1'b1;
        rdata[i*DW +: DW]  = ram_q_a;
      end else if (tag_b.valid && tag_b.idx == IDX_W'(i)) begin
        rvalid[i]          = 1'b1;
        rdata[i*DW +: DW]  = ram_q_b;
      end
    end
  end

`ifdef DPRAM_ARB_STATS_EN
  logic              skipped;
  logic [STAT_W:0]   grant_sum, conf_sum;

  assign skipped   = found_a && |(req_q & conflict & ~oh_a);
  assign grant_sum = {1'b0, stat_grants} + (STAT_W+1)'(found_a) + (STAT_W+1)'(found_b);
  assign conf_sum  = {1'b0, stat_conflicts} + (STAT_W+1)'(skipped);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else begin
      stat_grants    <= grant_sum[STAT_W] ? '1 : grant_sum[STAT_W-1:0];
      stat_conflicts <= conf_sum[STAT_W]  ? '1 : conf_sum[STAT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural dual-port RAM and read-data scoreboard.
module tb_dpram_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req, we, gnt, rvalid;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata, rdata;
  logic [AW-1:0]      ram_addr_a, ram_addr_b;
  logic [DW-1:0]      ram_data_a, ram_data_b, ram_q_a, ram_q_b;
  logic               ram_we_a, ram_we_b;
`ifdef DPRAM_ARB_STATS_EN
  logic [15:0]        stat_grants, stat_conflicts;
`endif

  dpram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
`ifdef DPRAM_ARB_STATS_EN
    .stat_grants(stat_grants), .stat_conflicts(stat_conflicts),
`endif
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  // behavioural synchronous dual-port RAM
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    ram_q_a <= mem[ram_addr_a];
    ram_q_b <= mem[ram_addr_b];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: {lane, data} expected one cycle after each accepted read
  logic [DW-1:0] ref_mem [64];
  logic [10:0]   exp_q[$];
  int            pushed_last = 0;
  int            rv3_cnt = 0;

  always @(negedge clk) begin : monitor
    int          n;
    logic [10:0] e;
    n = 0;
    if (rst) begin
      check("rst_rvalid", rvalid, 0);
      check("rst_gnt", gnt, 0);
      exp_q.delete();
      pushed_last = 0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (rvalid[i]) begin
          n++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7ff;
          check("rdata", {3'(i), rdata[i*DW +: DW]}, e);
        end
      end
      if (rvalid[3]) rv3_cnt++;
      check("rv_count", n, pushed_last);
      pushed_last = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i] && !we[i]) begin
          exp_q.push_back({3'(i), ref_mem[addr[i*AW +: AW]]});
          pushed_last++;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i] && we[i]) ref_mem[addr[i*AW +: AW]] = wdata[i*DW +: DW];
      end
    end
  end

  // driver tasks
  task automatic clr();
    req = '0; we = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_rq(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          gcnt [NREQ];
    int          p, base;
    logic [3:0]  eg;
    clr();
    // reset state with a request already pending
    set_rq(0, 1'b1, 6'h01, 8'haa);
    repeat (2) @(negedge clk);
    check("rst_ram_a", {ram_we_a, ram_addr_a, ram_data_a}, 0);
    check("rst_ram_b", {ram_we_b, ram_addr_b, ram_data_b}, 0);
    next();
    rst = 1'b0;
    clr();

    // two writes in one cycle
    set_rq(0, 1'b1, 6'h01, 8'h55);
    set_rq(1, 1'b1, 6'h02, 8'h66);
    @(negedge clk);
    check("t1_gnt", gnt, 4'b0011);
    check("t1_we", {ram_we_a, ram_we_b}, 2'b11);
    check("t1_addr", {ram_addr_a, ram_addr_b}, {6'h01, 6'h02});
    check("t1_data", {ram_data_a, ram_data_b}, 16'h5566);
    next();
    clr();

    // read back immediately, ptr now 1
    set_rq(2, 1'b0, 6'h02, 8'h00);
    set_rq(3, 1'b0, 6'h01, 8'h00);
    @(negedge clk);
    check("t2_gnt", gnt, 4'b1100);
    check("t2_we", {ram_we_a, ram_we_b}, 2'b00);
    check("t2_addr", {ram_addr_a, ram_addr_b}, {6'h02, 6'h01});
    next();
    clr();
    @(negedge clk);
    check("t2_rvalid", rvalid, 4'b1100);
    check("t2_lane2", rdata[2*DW +: DW], 8'h66);
    check("t2_lane3", rdata[3*DW +: DW], 8'h55);
    next();

    // same-address write conflict, ptr now 3
    set_rq(0, 1'b1, 6'h10, 8'h11);
    set_rq(1, 1'b1, 6'h10, 8'h22);
    @(negedge clk);
    check("t3_gnt0", gnt, 4'b0001);
    check("t3_we_b", ram_we_b, 1'b0);
    next();
    req[0] = 1'b0;
    we[0]  = 1'b0;
    @(negedge clk);
    check("t3_gnt1", gnt, 4'b0010);
    next();
    clr();
    set_rq(2, 1'b0, 6'h10, 8'h00);
    @(negedge clk);
    check("t3_rd_gnt", gnt, 4'b0100);
    next();
    clr();

    // fill every word through requester 0
    for (int k = 0; k < 64; k++) begin
      set_rq(0, 1'b1, 6'(k), 8'($urandom_range(0, 255)));
      @(negedge clk);
      check("fill_gnt", gnt, 4'b0001);
      next();
    end
    clr();

    // all four hold reads; ptr starts at 1 and advances by one per cycle
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) set_rq(i, 1'b0, 6'(i*16 + k), 8'h00);
      @(negedge clk);
      p  = (1 + k) % NREQ;
      eg = 4'(1 << p) | 4'(1 << ((p + 1) % NREQ));
      check("t4_gnt", gnt, eg);
      for (int i = 0; i < NREQ; i++) gcnt[i] += int'(gnt[i]);
      next();
    end
    clr();
    for (int i = 0; i < NREQ; i++) check("t4_count", gcnt[i], 4);

    // reset lands between a read grant and its data
    set_rq(2, 1'b0, 6'h05, 8'h00);
    @(negedge clk);
    check("t5_pre_gnt", gnt, 4'b0100);
    #2 rst = 1'b1;
    next();
    clr();
    @(negedge clk);
    next();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_rq(i, 1'b0, 6'(32 + i), 8'h00);
    @(negedge clk);
    check("t5_gnt", gnt, 4'b0011);
    check("t5_addr_a", ram_addr_a, 6'd32);
    next();
    clr();
    next();

    // lone requester 3 streams reads across the whole RAM
    base = rv3_cnt;
    for (int k = 0; k < 64; k++) begin
      set_rq(3, 1'b0, 6'(k), 8'h00);
      @(negedge clk);
      check("t6_gnt", gnt, 4'b1000);
      check("t6_portb", {ram_we_b, ram_addr_b, ram_data_b}, 0);
      next();
    end
    clr();
    next();
    check("t6_rv3", rv3_cnt - base, 64);

    next();
    check("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
